// File: rtl/imem_port_arbiter_pkg.sv
// Shared definitions for the instruction-memory port arbiter: widths, burst limit
// and the ownership state encoding.
package imem_port_arbiter_pkg;

  localparam int AW   = 14;
  localparam int DW   = 32;
  localparam int MAXW = 16384;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_LOAD   = 2'd2,
    ST_RESUME = 2'd3
  } arb_state_e;

endpackage

// File: rtl/imem_port_arbiter.sv
// Single-port instruction BRAM arbiter: fetch owns the port in RUN, the UART loader
// owns it in LOAD; DRAIN and RESUME sequence the handover and restart fetch at PC 0.
module imem_port_arbiter
  import imem_port_arbiter_pkg::*;
#(
  parameter int AW_P   = AW,
  parameter int DW_P   = DW,
  parameter int MAXW_P = MAXW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [AW_P-1:0]   if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DW_P-1:0]   if_rdata,
  input  logic              ld_start,
  input  logic              ld_we,
  input  logic [AW_P-1:0]   ld_addr,
  input  logic [DW_P-1:0]   ld_wdata,
  input  logic              ld_end,
  output logic              ld_own,
  output logic [AW_P:0]     ld_count,
  output logic              cpu_hold,
  output logic              pc_clr,
  output logic              mem_en,
  output logic              mem_we,
  output logic [AW_P-1:0]   mem_addr,
  output logic [DW_P-1:0]   mem_wdata,
  input  logic [DW_P-1:0]   mem_rdata
);

  localparam logic [AW_P:0] MAXW_C = (AW_P+1)'(MAXW_P);
  localparam logic [AW_P:0] ONE_C  = (AW_P+1)'(1);

  arb_state_e          state_r;
  arb_state_e          state_nx_s;
  logic                gnt_s;
  logic                en_s;
  logic                we_s;
  logic [AW_P-1:0]     addr_s;
  logic [DW_P-1:0]     wdata_s;
  logic                rvalid_r;
  logic                ld_own_r;
  logic                cpu_hold_r;
  logic                pc_clr_r;
  logic [AW_P:0]       count_r;

  // Next-state decode and combinational memory-port mux.
  always_comb begin
    state_nx_s = state_r;
    gnt_s      = 1'b0;
    en_s       = 1'b0;
    we_s       = 1'b0;
    addr_s     = if_addr;
    wdata_s    = '0;
    case (state_r)
      ST_RUN: begin
        gnt_s = if_req;
        en_s  = if_req;
        if (ld_start) begin
          state_nx_s = ST_DRAIN;
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        state_nx_s = ST_LOAD;
      end
      ST_LOAD: begin
        en_s    = ld_we;
        we_s    = ld_we;
        addr_s  = ld_addr;
        wdata_s = ld_wdata;
        if (ld_end) begin
          state_nx_s = ST_RESUME;
        end else begin
          state_nx_s = ST_LOAD;
        end
      end
      ST_RESUME: begin
        state_nx_s = ST_RUN;
      end
      default: begin
        state_nx_s = ST_RUN;
      end
    endcase
  end

  // State register, registered control outputs and the saturating burst counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= ST_RUN;
      rvalid_r   <= 1'b0;
      ld_own_r   <= 1'b0;
      cpu_hold_r <= 1'b0;
      pc_clr_r   <= 1'b0;
      count_r    <= '0;
    end else begin
      state_r    <= state_nx_s;
      rvalid_r   <= gnt_s;
      ld_own_r   <= (state_nx_s == ST_LOAD);
      cpu_hold_r <= (state_nx_s != ST_RUN);
      pc_clr_r   <= (state_nx_s == ST_RESUME);
      if (state_r == ST_DRAIN) begin
        count_r <= '0;
      end else if ((state_r == ST_LOAD) && ld_we && (count_r != MAXW_C)) begin
        count_r <= count_r + ONE_C;
      end else begin
        count_r <= count_r;
      end
    end
  end

  // Reset also silences the combinational port so no stray access escapes it.
  assign if_gnt    = rst_n & gnt_s;
  assign mem_en    = rst_n & en_s;
  assign mem_we    = rst_n & we_s;
  assign mem_addr  = addr_s;
  assign mem_wdata = wdata_s;

  assign if_rvalid = rvalid_r;
  assign if_rdata  = rvalid_r ? mem_rdata : '0;
  assign ld_own    = ld_own_r;
  assign cpu_hold  = cpu_hold_r;
  assign pc_clr    = pc_clr_r;
  assign ld_count  = count_r;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Self-checking bench for imem_port_arbiter: directed vector table, reset and
// saturation sequences, then random traffic against a behavioural ownership model.
module tb_imem_port_arbiter;

  localparam int AW   = 14;
  localparam int DW   = 32;
  localparam int MAXW = 16384;
  localparam int NW   = 16384;

  logic          clk;
  logic          rst_n;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          ld_start;
  logic          ld_we;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_wdata;
  logic          ld_end;
  logic          ld_own;
  logic [AW:0]   ld_count;
  logic          cpu_hold;
  logic          pc_clr;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  imem_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ld_start(ld_start), .ld_we(ld_we), .ld_addr(ld_addr),
    .ld_wdata(ld_wdata), .ld_end(ld_end), .ld_own(ld_own),
    .ld_count(ld_count), .cpu_hold(cpu_hold), .pc_clr(pc_clr),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench-side BRAM, 1-cycle read latency.
  logic [DW-1:0] bram [0:NW-1];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) bram[mem_addr] <= mem_wdata;
      else        mem_rdata      <= bram[mem_addr];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: who owns the port (0 cpu, 1 handing over, 2 loader, 3 restarting).
  logic [DW-1:0] m_mem [0:NW-1];
  int            m_phase = 0;
  int            m_count = 0;
  logic          m_rv    = 1'b0;
  logic [DW-1:0] m_rdata = '0;

  typedef struct {
    logic          req;   logic [AW-1:0] addr;  logic          start;
    logic          we;    logic [AW-1:0] laddr; logic [DW-1:0] wdata;
    logic          lend;
    logic          e_gnt; logic          e_rv;  logic [DW-1:0] e_rdata;
    logic          e_own; logic          e_hold; logic         e_pc;
    logic [AW:0]   e_cnt;
  } vec_t;

  vec_t tbl [18];
  vec_t cur;
  logic row_chk = 1'b0;

  task automatic step();
    logic e_gnt, e_en, e_we;
    @(negedge clk);
    e_gnt = rst_n && (m_phase == 0) && if_req;
    e_en  = rst_n && (((m_phase == 0) && if_req) || ((m_phase == 2) && ld_we));
    e_we  = rst_n && (m_phase == 2) && ld_we;
    chk("if_gnt", if_gnt, e_gnt);
    chk("mem_en", mem_en, e_en);
    chk("mem_we", mem_we, e_we);
    if (e_en) chk("mem_addr", mem_addr, (m_phase == 2) ? ld_addr : if_addr);
    if (e_we) chk("mem_wdata", mem_wdata, ld_wdata);
    chk("if_rvalid", if_rvalid, m_rv);
    chk("if_rdata", if_rdata, m_rv ? m_rdata : 32'h0);
    chk("ld_own", ld_own, m_phase == 2);
    chk("cpu_hold", cpu_hold, m_phase != 0);
    chk("pc_clr", pc_clr, m_phase == 3);
    chk("ld_count", ld_count, m_count);
    if (row_chk) begin
      chk("tbl_gnt", if_gnt, cur.e_gnt);
      chk("tbl_rvalid", if_rvalid, cur.e_rv);
      chk("tbl_rdata", if_rdata, cur.e_rdata);
      chk("tbl_own", ld_own, cur.e_own);
      chk("tbl_hold", cpu_hold, cur.e_hold);
      chk("tbl_pcclr", pc_clr, cur.e_pc);
      chk("tbl_count", ld_count, cur.e_cnt);
    end
    @(posedge clk);
    if (!rst_n) begin
      m_phase = 0;
      m_count = 0;
      m_rv    = 1'b0;
    end else begin
      m_rv = e_gnt;
      if (e_gnt) m_rdata = m_mem[if_addr];
      case (m_phase)
        0: if (ld_start) m_phase = 1;
        1: begin m_count = 0; m_phase = 2; end
        2: begin
          if (ld_we) begin
            m_mem[ld_addr] = ld_wdata;
            if (m_count < MAXW) m_count++;
          end
          if (ld_end) m_phase = 3;
        end
        default: m_phase = 0;
      endcase
    end
    #1;
  endtask

  task automatic idle();
    if_req = 1'b0; if_addr = '0; ld_start = 1'b0; ld_we = 1'b0;
    ld_addr = '0; ld_wdata = '0; ld_end = 1'b0;
  endtask

  initial begin
    logic pc_seen;
    rst_n = 1'b0;
    idle();
    for (int i = 0; i < NW; i++) begin
      bram[i]  = 32'hA500_0000 | 32'(i);
      m_mem[i] = 32'hA500_0000 | 32'(i);
    end
    bram[6]  = 32'h0050_0093;
    m_mem[6] = 32'h0050_0093;

    //            req   addr    st    we    laddr   wdata         end   gnt   rv    rdata         own   hold  pc    cnt
    tbl[0]  = '{1'b1, 14'd6, 1'b0, 1'b0, 14'd0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 15'd0};
    tbl[1]  = '{1'b0, 14'd0, 1'b0, 1'b0, 14'd0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h00500093, 1'b0, 1'b0, 1'b0, 15'd0};
    tbl[2]  = '{1'b1, 14'd3, 1'b1, 1'b0, 14'd0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 15'd0};
    tbl[3]  = '{1'b1, 14'd3, 1'b1, 1'b0, 14'd0, 32'h0,        1'b0, 1'b0, 1'b1, 32'hA5000003, 1'b0, 1'b1, 1'b0, 15'd0};
    tbl[4]  = '{1'b1, 14'd3, 1'b1, 1'b1, 14'd0, 32'h11,       1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 15'd0};
    tbl[5]  = '{1'b1, 14'd0, 1'b0, 1'b1, 14'd1, 32'h22,       1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 15'd1};
    tbl[6]  = '{1'b0, 14'd0, 1'b0, 1'b1, 14'd2, 32'h33,       1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 15'd2};
    tbl[7]  = '{1'b0, 14'd0, 1'b0, 1'b1, 14'd3, 32'h44,       1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 15'd3};
    tbl[8]  = '{1'b0, 14'd0, 1'b0, 1'b1, 14'd4, 32'h55,       1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 15'd4};
    tbl[9]  = '{1'b1, 14'd0, 1'b0, 1'b0, 14'd0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 15'd5};
    tbl[10] = '{1'b1, 14'd0, 1'b0, 1'b0, 14'd0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 15'd5};
    tbl[11] = '{1'b1, 14'd1, 1'b0, 1'b0, 14'd0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h11,       1'b0, 1'b0, 1'b0, 15'd5};
    tbl[12] = '{1'b1, 14'd2, 1'b0, 1'b0, 14'd0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h22,       1'b0, 1'b0, 1'b0, 15'd5};
    tbl[13] = '{1'b1, 14'd3, 1'b0, 1'b0, 14'd0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h33,       1'b0, 1'b0, 1'b0, 15'd5};
    tbl[14] = '{1'b1, 14'd4, 1'b0, 1'b0, 14'd0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h44,       1'b0, 1'b0, 1'b0, 15'd5};
    tbl[15] = '{1'b0, 14'd0, 1'b0, 1'b0, 14'd0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h55,       1'b0, 1'b0, 1'b0, 15'd5};
    tbl[16] = '{1'b0, 14'd0, 1'b0, 1'b1, 14'd7, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 15'd5};
    tbl[17] = '{1'b0, 14'd0, 1'b0, 1'b0, 14'd0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 15'd5};

    // Reset state
    step();
    step();
    chk("rst_own", ld_own, 1'b0);
    chk("rst_hold", cpu_hold, 1'b0);
    chk("rst_pcclr", pc_clr, 1'b0);
    chk("rst_count", ld_count, 15'd0);
    chk("rst_rvalid", if_rvalid, 1'b0);
    chk("rst_rdata", if_rdata, 32'h0);
    rst_n = 1'b1;

    // Directed fetch / handover / load / refetch / ignored-in-RUN sequence
    for (int i = 0; i < 18; i++) begin
      cur = tbl[i];
      if_req = cur.req; if_addr = cur.addr; ld_start = cur.start; ld_we = cur.we;
      ld_addr = cur.laddr; ld_wdata = cur.wdata; ld_end = cur.lend;
      row_chk = 1'b1;
      step();
    end
    row_chk = 1'b0;
    chk("run_ignore_bram7", bram[7], 32'hA5000007);

    // Reset held two cycles in the middle of a load
    idle();
    ld_start = 1'b1;
    step();
    step();
    chk("midload_own", ld_own, 1'b1);
    ld_start = 1'b0; ld_we = 1'b1; ld_addr = 14'd9; ld_wdata = 32'h9999_0000;
    step();
    step();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    idle();
    chk("midrst_own", ld_own, 1'b0);
    chk("midrst_hold", cpu_hold, 1'b0);
    pc_seen = 1'b0;
    if_req = 1'b1; if_addr = 14'd9;
    for (int i = 0; i < 4; i++) begin
      step();
      pc_seen = pc_seen | pc_clr;
    end
    chk("midrst_no_pcclr", pc_seen, 1'b0);

    // Burst of MAXW+1 writes: count saturates
    idle();
    ld_start = 1'b1;
    step();
    step();
    ld_start = 1'b0;
    for (int k = 0; k <= MAXW; k++) begin
      ld_we = 1'b1; ld_addr = AW'(k); ld_wdata = $urandom; ld_end = (k == MAXW);
      step();
    end
    idle();
    chk("sat_count", ld_count, 15'd16384);
    chk("sat_pcclr", pc_clr, 1'b1);
    step();
    step();
    chk("sat_count_hold", ld_count, 15'd16384);

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      rst_n    = ($urandom_range(0, 299) != 0);
      if_req   = 1'($urandom);
      if_addr  = AW'($urandom_range(0, 15));
      ld_start = ($urandom_range(0, 15) == 0) || (ld_start && !ld_own);
      ld_we    = 1'($urandom);
      ld_addr  = AW'($urandom_range(0, 15));
      ld_wdata = $urandom;
      ld_end   = ($urandom_range(0, 9) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
